// File: rtl/mem_store_merge_if.sv
// Store-request and word-memory signals of mem_store_merge, bundled as one interface.
// slave is the merge unit's view; master is the MEM stage / memory side.
interface mem_store_merge_if;
  logic        st_req;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_misalign;
  logic        st_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  modport slave (
    input  st_req, st_size, st_addr, st_data, mem_rdata, mem_ack,
    output st_busy, st_done, st_misalign, st_err,
           mem_addr, mem_rd, mem_wr, mem_wdata, dbg_state
  );

  modport master (
    output st_req, st_size, st_addr, st_data, mem_rdata, mem_ack,
    input  st_busy, st_done, st_misalign, st_err,
           mem_addr, mem_rd, mem_wr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/mem_store_merge.sv
// Store merge unit: turns byte/halfword stores into read-modify-write sequences on a
// word-only memory, word stores into a single write; flags misalignment and hung acks.
module mem_store_merge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  mem_store_merge_if.slave bus
);

  // Handshake: st_req is sampled only while idle; a request is consumed on that edge and
  // answered by exactly one of st_done/st_misalign/st_err. mem_rd/mem_wr are held high
  // until an edge with mem_ack=1 (or timeout); mem_rdata is taken on the read-ack edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int unsigned CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic [15:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;

  logic          misaligned;
  logic          expire;
  logic [31:0]   merged;

  always_comb begin
    misaligned = 1'b0;
    case (bus.st_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.st_addr[0];
      2'b10:   misaligned = |bus.st_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // The strobe has waited its last allowed cycle when the counter sits at TIMEOUT_CYC-1
  // and this edge still sees no ack.
  assign expire = !bus.mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      data_q  <= 16'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.st_req && !misaligned) begin
          state_d = (bus.st_size == 2'b10) ? WR : RD;
        end
      end
      RD: begin
        if (bus.mem_ack) begin
          state_d = WR;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        if (bus.mem_ack || expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    size_d  = size_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.st_req) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            addr_d = {bus.st_addr[31:2], 2'b00};
            size_d = bus.st_size;
            lane_d = bus.st_addr[1:0];
            data_d = bus.st_data[15:0];
            if (bus.st_size == 2'b10) wdata_d = bus.st_data;
          end
        end
      end
      RD: begin
        if (bus.mem_ack) wdata_d = merged;
        else if (expire) err_d = 1'b1;
      end
      WR: begin
        if (bus.mem_ack) done_d = 1'b1;
        else if (expire) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.st_busy     = (state_q != IDLE);
  assign bus.st_done     = done_q;
  assign bus.st_misalign = mis_q;
  assign bus.st_err      = err_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd      = (state_q == RD);
  assign bus.mem_wr      = (state_q == WR);
  assign bus.mem_wdata   = wdata_q;
  assign bus.dbg_state   = state_q;

endmodule
